// File: rtl/emmc_dev_cmd_responder_if.sv
// ---------------------------------------------------------------------------
// emmc_dev_cmd_responder_if
// Bundles the CMD line pins and the command/response handshake between the
// eMMC device-side CMD responder and the device logic that serves it.
//   slave  : the responder itself (samples cmd_i, drives cmd_o/cmd_oe_o,
//            presents received commands, accepts responses).
//   master : the device logic / bench (drives cmd_i and the response offer).
// Signals:
//   cmd_i, cmd_o, cmd_oe_o           CMD line level in, level out, output enable
//   cmd_valid_o, cmd_err_o           one-cycle pulses: good command / bad token
//   cmd_idx_o[5:0], cmd_arg_o[31:0]  last good command index and argument
//   rsp_valid_i, rsp_ready_o         response handshake
//   rsp_type_i[1:0], rsp_data_i[127:0] response kind and payload
//   busy_o                           responder not idle
// ---------------------------------------------------------------------------
interface emmc_dev_cmd_responder_if;
    logic         cmd_i;
    logic         cmd_o;
    logic         cmd_oe_o;
    logic         cmd_valid_o;
    logic [5:0]   cmd_idx_o;
    logic [31:0]  cmd_arg_o;
    logic         cmd_err_o;
    logic         rsp_valid_i;
    logic         rsp_ready_o;
    logic [1:0]   rsp_type_i;
    logic [127:0] rsp_data_i;
    logic         busy_o;

    modport slave (
        input  cmd_i, rsp_valid_i, rsp_type_i, rsp_data_i,
        output cmd_o, cmd_oe_o, cmd_valid_o, cmd_idx_o, cmd_arg_o, cmd_err_o,
               rsp_ready_o, busy_o
    );

    modport master (
        output cmd_i, rsp_valid_i, rsp_type_i, rsp_data_i,
        input  cmd_o, cmd_oe_o, cmd_valid_o, cmd_idx_o, cmd_arg_o, cmd_err_o,
               rsp_ready_o, busy_o
    );
endinterface

// File: rtl/emmc_dev_cmd_responder.sv
// ---------------------------------------------------------------------------
// emmc_dev_cmd_responder
// Device-side end of the eMMC CMD line. Deserialises 48-bit host command
// tokens, checks the transmission bit, CRC7 and end bit, presents the command
// index/argument, then serialises the R1/R3 (48-bit) or R2 (136-bit) response
// supplied by the device logic after the NCR turnaround.
// Parameters:
//   NCR_CYCLES  clocks from end-bit sampling edge to start-bit drive (2..63)
//   RSP_TIMEOUT clocks after the end bit within which a response is accepted
// Ports:
//   clk    CMD line clock, rising edge
//   rst_n  asynchronous active-low reset; aborts any frame and frees the line
//   bus    emmc_dev_cmd_responder_if.slave (CMD pins + command/response I/F)
// ---------------------------------------------------------------------------
module emmc_dev_cmd_responder #(
    parameter int NCR_CYCLES  = 2,
    parameter int RSP_TIMEOUT = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    emmc_dev_cmd_responder_if.slave         bus
);
    // Wait counter must reach RSP_TIMEOUT and keep counting through TX_WAIT.
    localparam int              CW        = $clog2(RSP_TIMEOUT + NCR_CYCLES + 4);
    localparam logic [CW-1:0]   TIMEOUT_C = CW'(RSP_TIMEOUT);
    localparam logic [CW-1:0]   START_C   = CW'(NCR_CYCLES + 1);
    localparam logic [CW-1:0]   ONE_C     = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        RX,
        SKIP,
        WAIT_RSP,
        TX_WAIT,
        TX
    } state_t;

    state_t         state_reg,    state_next;
    logic [5:0]     bit_cnt_reg,  bit_cnt_next;   // token bits received so far
    logic [44:0]    rx_shift_reg, rx_shift_next;  // idx, arg, crc after 46 shifts
    logic [6:0]     crc_reg,      crc_next;       // shared by RX and TX
    logic [CW-1:0]  wait_cnt_reg, wait_cnt_next;  // clocks since end-bit edge
    logic [135:0]   tx_shift_reg, tx_shift_next;  // MSB-aligned response frame
    logic [7:0]     tx_cnt_reg,   tx_cnt_next;    // response bits driven so far
    logic           tx_long_reg,  tx_long_next;   // 136-bit R2 frame
    logic           tx_crc_reg,   tx_crc_next;    // R1: CRC7 generated on the fly
    logic           release_reg,  release_next;   // line just released: ignore cmd_i
    logic           cmd_o_reg,    cmd_o_next;
    logic           cmd_oe_reg,   cmd_oe_next;
    logic           valid_reg,    valid_next;
    logic           err_reg,      err_next;
    logic [5:0]     idx_reg,      idx_next;
    logic [31:0]    arg_reg,      arg_next;

    // One bit of the x^7 + x^3 + 1 LFSR, MSB-first data.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            rx_shift_reg <= '0;
            crc_reg      <= '0;
            wait_cnt_reg <= '0;
            tx_shift_reg <= '0;
            tx_cnt_reg   <= '0;
            tx_long_reg  <= 1'b0;
            tx_crc_reg   <= 1'b0;
            release_reg  <= 1'b0;
            cmd_o_reg    <= 1'b1;
            cmd_oe_reg   <= 1'b0;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
            idx_reg      <= '0;
            arg_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            rx_shift_reg <= rx_shift_next;
            crc_reg      <= crc_next;
            wait_cnt_reg <= wait_cnt_next;
            tx_shift_reg <= tx_shift_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_long_reg  <= tx_long_next;
            tx_crc_reg   <= tx_crc_next;
            release_reg  <= release_next;
            cmd_o_reg    <= cmd_o_next;
            cmd_oe_reg   <= cmd_oe_next;
            valid_reg    <= valid_next;
            err_reg      <= err_next;
            idx_reg      <= idx_next;
            arg_reg      <= arg_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        rx_shift_next = rx_shift_reg;
        crc_next      = crc_reg;
        wait_cnt_next = wait_cnt_reg;
        tx_shift_next = tx_shift_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_long_next  = tx_long_reg;
        tx_crc_next   = tx_crc_reg;
        release_next  = 1'b0;
        cmd_o_next    = cmd_o_reg;
        cmd_oe_next   = cmd_oe_reg;
        valid_next    = 1'b0;
        err_next      = 1'b0;
        idx_next      = idx_reg;
        arg_next      = arg_reg;

        case (state_reg)
            IDLE: begin
                if (!bus.cmd_i && !cmd_oe_reg && !release_reg) begin
                    // Start bit is 0, so it leaves the zero-initialised CRC unchanged.
                    state_next   = RX;
                    bit_cnt_next = 6'd1;
                    crc_next     = 7'd0;
                end
            end

            RX: begin
                bit_cnt_next  = bit_cnt_reg + 6'd1;
                rx_shift_next = {rx_shift_reg[43:0], bus.cmd_i};
                // CRC covers token bits 1..40 (start through arg[0]).
                if (bit_cnt_reg <= 6'd39) begin
                    crc_next = crc7_step(crc_reg, bus.cmd_i);
                end
                if (bit_cnt_reg == 6'd1 && !bus.cmd_i) begin
                    // Transmission bit 0: another device's response on the bus.
                    state_next = SKIP;
                end else if (bit_cnt_reg == 6'd47) begin
                    if (bus.cmd_i && (rx_shift_reg[6:0] == crc_reg)) begin
                        valid_next    = 1'b1;
                        idx_next      = rx_shift_reg[44:39];
                        arg_next      = rx_shift_reg[38:7];
                        wait_cnt_next = ONE_C;
                        state_next    = WAIT_RSP;
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            SKIP: begin
                if (bit_cnt_reg == 6'd47) begin
                    state_next = IDLE;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 6'd1;
                end
            end

            WAIT_RSP: begin
                wait_cnt_next = wait_cnt_reg + ONE_C;
                if (bus.rsp_valid_i) begin
                    if (bus.rsp_type_i == 2'd0) begin
                        state_next = IDLE;
                    end else begin
                        tx_long_next = (bus.rsp_type_i == 2'd2);
                        tx_crc_next  = (bus.rsp_type_i == 2'd1);
                        crc_next     = 7'd0;
                        if (bus.rsp_type_i == 2'd2) begin
                            tx_shift_next = {2'b00, 6'h3F, bus.rsp_data_i[127:1], 1'b1};
                        end else begin
                            // R3 carries all-ones in place of index and CRC; for
                            // R1 the CRC slot is overridden while shifting out.
                            tx_shift_next = {2'b00,
                                             (bus.rsp_type_i == 2'd3) ? 6'h3F : idx_reg,
                                             bus.rsp_data_i[31:0], 7'h7F, 1'b1, 88'd0};
                        end
                        state_next = TX_WAIT;
                    end
                end else if (!bus.cmd_i) begin
                    // New host token before any response: abandon and decode it.
                    state_next   = RX;
                    bit_cnt_next = 6'd1;
                    crc_next     = 7'd0;
                end else if (wait_cnt_reg == TIMEOUT_C) begin
                    state_next = IDLE;
                end
            end

            TX_WAIT: begin
                wait_cnt_next = wait_cnt_reg + ONE_C;
                if (wait_cnt_reg >= START_C) begin
                    cmd_oe_next   = 1'b1;
                    cmd_o_next    = tx_shift_reg[135];
                    tx_shift_next = {tx_shift_reg[134:0], 1'b1};
                    crc_next      = crc7_step(crc_reg, tx_shift_reg[135]);
                    tx_cnt_next   = 8'd1;
                    state_next    = TX;
                end
            end

            TX: begin
                if (tx_cnt_reg == (tx_long_reg ? 8'd136 : 8'd48)) begin
                    cmd_oe_next  = 1'b0;
                    cmd_o_next   = 1'b1;
                    release_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    tx_cnt_next   = tx_cnt_reg + 8'd1;
                    tx_shift_next = {tx_shift_reg[134:0], 1'b1};
                    if (tx_crc_reg && tx_cnt_reg >= 8'd40 && tx_cnt_reg <= 8'd46) begin
                        cmd_o_next = crc_reg[6];
                        crc_next   = {crc_reg[5:0], 1'b0};
                    end else begin
                        cmd_o_next = tx_shift_reg[135];
                        if (tx_cnt_reg < 8'd40) begin
                            crc_next = crc7_step(crc_reg, tx_shift_reg[135]);
                        end
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.cmd_o       = cmd_o_reg;
    assign bus.cmd_oe_o    = cmd_oe_reg;
    assign bus.cmd_valid_o = valid_reg;
    assign bus.cmd_err_o   = err_reg;
    assign bus.cmd_idx_o   = idx_reg;
    assign bus.cmd_arg_o   = arg_reg;
    assign bus.rsp_ready_o = (state_reg == WAIT_RSP);
    assign bus.busy_o      = (state_reg != IDLE);

endmodule

// File: doc/emmc_dev_cmd_responder.md
Name: emmc_dev_cmd_responder

Overview:
Device-side end of the eMMC CMD line: deserialises host command tokens, checks framing and CRC7, and presents the command index and argument to the device logic. It then serialises the R1/R3 (48-bit) or R2 (136-bit) response the device logic supplies, honouring the NCR turnaround. It serves as the counterpart to the host command/response engine and is used as the bus-functional device in system benches.

Parameters:
NCR_CYCLES, 2, clock periods from end-bit sampling to start-bit drive; legal range 2..63.
RSP_TIMEOUT, 64, clock periods after end bit within which a response must be accepted; otherwise it is dropped.

Ports:
clk  in  1  CMD line clock; all flops are rising-edge.
rst_n  in  1  asynchronous active-low reset.
cmd_i  in  1  sampled CMD line level.
cmd_o  out  1  driven CMD level.
cmd_oe_o  out  1  CMD output enable.
cmd_valid_o  out  1  one-cycle pulse: good command received.
cmd_idx_o  out  6  command index, valid from cmd_valid_o until the next token.
cmd_arg_o  out  32  command argument, same validity as cmd_idx_o.
cmd_err_o  out  1  one-cycle pulse: CRC7 or end-bit error.
rsp_valid_i  in  1  response offered.
rsp_ready_o  out  1  high in WAIT_RSP; transfer when valid & ready.
rsp_type_i  in  2  0 none, 1 R1 (48-bit), 2 R2 (136-bit), 3 R3 (48-bit).
rsp_data_i  in  128  R1/R3 use [31:0] as the card-status/OCR payload; R2 uses [127:1], which is CID/CSD including the internal CRC.
busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state IDLE, cmd_o=1, cmd_oe_o=0, cmd_valid_o=0, cmd_err_o=0, cmd_idx_o=0, cmd_arg_o=0, rsp_ready_o=0. Assertion mid-frame aborts immediately and releases the line.
- IDLE: cmd_i=0 (start bit) with cmd_oe_o=0 -> RX with bit counter 1.
- RX: shift 47 further bits, MSB first: transmission bit, idx[5:0], arg[31:0], crc[6:0], end bit.
  - Transmission bit 0 means a response from another device: go to SKIP and ignore 46 more bits, then IDLE.
- CRC7: polynomial x^7+x^3+1, initial value 0, computed over the 40 bits from start bit through arg[0].
- End-bit sampling edge E:
  - CRC match and end=1: cmd_valid_o pulses in cycle E+1, idx/arg update, -> WAIT_RSP.
  - Otherwise: cmd_err_o pulses in cycle E+1, idx/arg are held, -> IDLE with no response.
- WAIT_RSP: rsp_ready_o=1; counter n counts cycles since E.
  - Accept with rsp_type_i=0 -> IDLE.
  - Accept with a nonzero type: latch type and data, drop ready, -> TX_WAIT.
  - n reaching RSP_TIMEOUT without acceptance -> IDLE with no drive.
- TX_WAIT: start bit is driven at edge E+NCR_CYCLES+1 if accepted by then, else at the edge after acceptance. cmd_oe_o rises together with the start bit.
- TX 48-bit frame: 0, 0, idx6, payload32, crc7, 1.
  - R1: idx = received cmd_idx_o; crc = CRC7 computed on the fly over the first 40 transmitted bits.
  - R3: idx = 6'b111111; crc = 7'b1111111.
- TX R2 frame: 0, 0, 6'b111111, rsp_data_i[127:1], 1 (136 bits total).
- After the end bit, cmd_oe_o=0 and cmd_o=1 on the next edge, -> IDLE.
  - cmd_i is ignored while cmd_oe_o=1 and during the release cycle.
- No pipelining: tokens arriving in WAIT_RSP/TX_WAIT/TX are not decoded. A start bit seen in WAIT_RSP aborts WAIT_RSP, pulses nothing, and is decoded as a new token.

Test Plan:
- CMD0 token 0x40_00000000_95 -> cmd_valid_o at E+1, idx=0, arg=0. Respond type 0 -> cmd_oe_o stays 0 and the block returns to IDLE.
- CMD17 token 0x51_00000000_55, then R1 with rsp_data_i[31:0]=0x00000900 offered at E+1 -> start bit at E+NCR_CYCLES+1; cmd_o serial stream 0x11_00000900_67, 48 bits; cmd_oe_o high for exactly 48 cycles.
- CMD17 token with corrupted CRC byte 0x57 -> cmd_err_o pulses once, no cmd_valid_o, no drive, rsp_ready_o stays 0.
- R3 with payload 0xC0FF8080 -> stream 0x3F_C0FF8080_FF. R2 with rsp_data_i=128'h1501_0041_3031_3233_3400_0000_0000_00FF -> 136 bits; last 8 bits 0xFF; idx field 111111.
- Response offered at E+80 -> timeout at E+64, rsp_ready_o drops, line never driven.
- rst_n asserted mid-TX at bit 20 -> cmd_oe_o=0 and cmd_o=1 asynchronously. After release, a clean CMD0 is decoded normally.
